// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg
// Shared types for the sound event sequencer and the sound_generator tone
// datapath.
//   tone_t      : tone select seen by sound_generator (NONE, DIR, GOOD, BAD).
//                 The numeric order is also the request priority order.
//   seq_state_t : sequencer FSM states (IDLE, PLAY, GAP).
//   highest_tone: picks the highest-priority pending request.
// ---------------------------------------------------------------------------
package sound_pkg;

    typedef enum logic [1:0] {
        TONE_NONE = 2'd0,
        TONE_DIR  = 2'd1,
        TONE_GOOD = 2'd2,
        TONE_BAD  = 2'd3
    } tone_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    // Fixed priority: bad > good > dir.
    function automatic tone_t highest_tone(input logic bad, input logic good,
                                           input logic dir);
        if (bad)
            return TONE_BAD;
        else if (good)
            return TONE_GOOD;
        else if (dir)
            return TONE_DIR;
        else
            return TONE_NONE;
    endfunction

endpackage

// File: rtl/event_edge_det.sv
// ---------------------------------------------------------------------------
// event_edge_det
// Registers the previous value of an input bus and flags edges against it.
// While rst is high the register tracks the live input, so a level that is
// already present when reset releases is not reported as an edge.
// Ports:
//   clk     in  1 : system clock
//   rst     in  1 : synchronous, active-high reset
//   sig     in  W : input to watch
//   rise    out W : per-bit rising edge (sig & ~previous)
//   changed out 1 : sig differs from its previous value
// ---------------------------------------------------------------------------
module event_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sig,
    output logic [W-1:0] rise,
    output logic         changed
);

    logic [W-1:0] sig_q;

    always_ff @(posedge clk) begin
        if (rst)
            sig_q <= sig;
        else
            sig_q <= sig;
    end

    assign rise    = sig & ~sig_q;
    assign changed = (sig != sig_q);

endmodule

// File: rtl/sound_event_sequencer.sv
// ---------------------------------------------------------------------------
// sound_event_sequencer
// Shares the single sound_generator tone datapath between three event
// requesters (bad collision, good collision, direction change) and owns the
// user mute toggle. Events are edge-detected, latched as pending requests and
// granted one at a time in fixed priority (bad > good > dir). Each tone plays
// for its LEN cycles and is followed by GAP_LEN silent cycles.
//
// Optional feature macro: SOUND_PREEMPT_EN
//   defined   : a strictly higher-priority request pending during PLAY takes
//               over immediately (no gap); the interrupted tone is dropped.
//   undefined : requests wait in pending until the FSM returns to IDLE.
//
// Ports:
//   clk         in  1 : system clock
//   rst         in  1 : synchronous, active-high reset
//   button_i    in  1 : mute toggle (rising edge)
//   goodColl_i  in  1 : good collision (rising edge)
//   badColl_i   in  1 : bad collision (rising edge)
//   direction_i in  4 : one-hot snake direction, 0 = none
//   mute_o      out 1 : sound muted
//   play_o      out 1 : tone playing
//   tone_o      out 2 : tone select (0 none, 1 dir, 2 good, 3 bad)
//   busy_o      out 1 : FSM in PLAY or GAP
// ---------------------------------------------------------------------------
module sound_event_sequencer
    import sound_pkg::*;
#(
    parameter int CNT_W    = 24,
    parameter int BAD_LEN  = 5_000_000,
    parameter int GOOD_LEN = 2_500_000,
    parameter int DIR_LEN  = 500_000,
    parameter int GAP_LEN  = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_i,
    input  logic       goodColl_i,
    input  logic       badColl_i,
    input  logic [3:0] direction_i,
    output logic       mute_o,
    output logic       play_o,
    output logic [1:0] tone_o,
    output logic       busy_o
);

    function automatic logic [CNT_W-1:0] len_m1(input tone_t t);
        case (t)
            TONE_BAD:  return CNT_W'(BAD_LEN - 1);
            TONE_GOOD: return CNT_W'(GOOD_LEN - 1);
            TONE_DIR:  return CNT_W'(DIR_LEN - 1);
            default:   return '0;
        endcase
    endfunction

    // Edge detection
    logic       btn_rise, good_rise, bad_rise;
    logic       btn_chg, good_chg, bad_chg, dir_chg;
    logic [3:0] dir_rise;

    event_edge_det #(.W(1)) u_btn_det (
        .clk(clk), .rst(rst), .sig(button_i), .rise(btn_rise), .changed(btn_chg)
    );
    event_edge_det #(.W(1)) u_good_det (
        .clk(clk), .rst(rst), .sig(goodColl_i), .rise(good_rise), .changed(good_chg)
    );
    event_edge_det #(.W(1)) u_bad_det (
        .clk(clk), .rst(rst), .sig(badColl_i), .rise(bad_rise), .changed(bad_chg)
    );
    event_edge_det #(.W(4)) u_dir_det (
        .clk(clk), .rst(rst), .sig(direction_i), .rise(dir_rise), .changed(dir_chg)
    );

    // Only the rise of the 1-bit inputs and the change flag of the direction
    // bus are meaningful events; the other outputs are intentionally dropped.
    logic unused_edges;
    assign unused_edges = ^{btn_chg, good_chg, bad_chg, dir_rise};

    logic btn_ev, good_ev, bad_ev, dir_ev;
    assign btn_ev  = btn_rise;
    assign good_ev = good_rise;
    assign bad_ev  = bad_rise;
    assign dir_ev  = dir_chg && (direction_i != 4'd0);

    // Sequencer state
    seq_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    tone_t            tone_q, tone_n, grant;
    logic             play_n;
    logic             pend_bad, pend_good, pend_dir;
    logic             pend_bad_n, pend_good_n, pend_dir_n;
    logic             do_grant, preempt;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tone_n      = tone_q;
        play_n      = play_o;
        pend_bad_n  = pend_bad;
        pend_good_n = pend_good;
        pend_dir_n  = pend_dir;
        do_grant    = 1'b0;
        grant       = highest_tone(pend_bad, pend_good, pend_dir);
`ifdef SOUND_PREEMPT_EN
        preempt     = (state == PLAY) && (grant > tone_q);
`else
        preempt     = 1'b0;
`endif

        case (state)
            IDLE: begin
                do_grant = (grant != TONE_NONE);
            end
            PLAY: begin
                if (preempt) begin
                    do_grant = 1'b1;
                end else if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = CNT_W'(GAP_LEN - 1);
                    play_n  = 1'b0;
                    tone_n  = TONE_NONE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0)
                    state_n = IDLE;
                else
                    cnt_n = cnt - CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase

        if (do_grant) begin
            state_n = PLAY;
            cnt_n   = len_m1(grant);
            tone_n  = grant;
            play_n  = 1'b1;
            case (grant)
                TONE_BAD:  pend_bad_n  = 1'b0;
                TONE_GOOD: pend_good_n = 1'b0;
                TONE_DIR:  pend_dir_n  = 1'b0;
                default:   ;
            endcase
        end

        // New events are applied after the grant clear so a retrigger of the
        // tone just granted stays pending and replays after the gap.
        if (!mute_o) begin
            pend_bad_n  = pend_bad_n  | bad_ev;
            pend_good_n = pend_good_n | good_ev;
            pend_dir_n  = pend_dir_n  | dir_ev;
        end

        // Muted: silence everything and drop all requests.
        if (mute_o) begin
            state_n     = IDLE;
            tone_n      = TONE_NONE;
            play_n      = 1'b0;
            pend_bad_n  = 1'b0;
            pend_good_n = 1'b0;
            pend_dir_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tone_q    <= TONE_NONE;
            play_o    <= 1'b0;
            mute_o    <= 1'b0;
            pend_bad  <= 1'b0;
            pend_good <= 1'b0;
            pend_dir  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tone_q    <= tone_n;
            play_o    <= play_n;
            mute_o    <= mute_o ^ btn_ev;
            pend_bad  <= pend_bad_n;
            pend_good <= pend_good_n;
            pend_dir  <= pend_dir_n;
        end
    end

    assign tone_o = tone_q;
    assign busy_o = (state != IDLE);

endmodule

// File: doc/sound_event_sequencer.md
# sound_event_sequencer

Schedules playback of game sound effects by sharing the single `sound_generator` tone datapath among three event requesters: bad collision, good collision and direction change. It also owns the user mute toggle. It sits between game-logic event signals and `sound_generator`. It edge-detects events, latches them as pending requests, grants the highest-priority one and times each tone and the silent gap after it.

## Interface
Parameters:
- `CNT_W`, 24: duration counter width.
- `BAD_LEN`, 5_000_000: bad-collision tone length in cycles (≥1).
- `GOOD_LEN`, 2_500_000: good-collision tone length in cycles (≥1).
- `DIR_LEN`, 500_000: direction-change tone length in cycles (≥1).
- `GAP_LEN`, 100_000: silent gap after each tone in cycles (≥1).

Ports:
- `clk` in 1: system clock; one clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `button_i` in 1: mute toggle; acts on the rising edge.
- `goodColl_i` in 1: good collision; acts on the rising edge.
- `badColl_i` in 1: bad collision; acts on the rising edge.
- `direction_i` in 4: one-hot snake direction; 0 means none.
- `mute_o` out 1: 1 while sound is muted.
- `play_o` out 1: 1 while a tone is playing.
- `tone_o` out 2: tone select. 0 none, 1 dir, 2 good, 3 bad.
- `busy_o` out 1: 1 in PLAY or GAP.

## Operation
- Edge detect:
  - Registers `btn_q`, `good_q`, `bad_q`, `dir_q` hold the previous inputs.
  - During reset these registers load the current inputs, so inputs held through reset release produce no event.
  - A direction event occurs when `direction_i != dir_q` and `direction_i != 0`.
- Mute:
  - A button rising edge toggles `mute_o`.
  - While muted, events are discarded and never set pending.
  - Muting in PLAY or GAP forces IDLE on the next edge, clears all pending flags and drives `play_o`/`tone_o` to 0.
- Pending: three flags, `pend_bad`, `pend_good` and `pend_dir`.
  - A flag sets on its event while unmuted.
  - A flag clears when its request is granted.
  - An event that arrives while its own flag is already set is merged (no counting).
- Priority is fixed: bad > good > dir.
- FSM states IDLE, PLAY, GAP:
  - IDLE: if any flag is pending, grant the highest, load `cnt = LEN-1`, set `tone_o` and `play_o = 1`, and go to PLAY.
  - PLAY: if `cnt == 0`, load `cnt = GAP_LEN-1`, set `play_o = 0` and `tone_o = 0`, and go to GAP. Otherwise decrement.
  - GAP: if `cnt == 0`, go to IDLE. Otherwise decrement.
- Simultaneous events in one cycle: all flags set; they are granted in priority order, one per IDLE visit.
- A retrigger of the event currently playing sets its pending flag, so it replays after the gap.
- Button edge coinciding with an event in the same cycle: the event is evaluated against the pre-toggle `mute_o`.

## Timing
- Reset values: `mute_o = 0`, `play_o = 0`, `tone_o = 0`, `busy_o = 0`, state IDLE, pending flags 0, `cnt = 0`.
- Latency:
  - An input edge sampled at posedge N sets the pending flag after N.
  - From IDLE, `play_o` and `tone_o` are valid after posedge N+1, i.e. 2 cycles from input to tone.
- `play_o` is high for exactly LEN cycles, then low for GAP_LEN cycles in GAP, then at least 1 IDLE cycle before the next grant.
- Period between back-to-back tones = LEN + GAP_LEN + 1 cycles.
- Mute takes effect 1 cycle after the button edge is sampled.

## Configuration
- `SOUND_PREEMPT_EN` defined:
  - In PLAY, a pending flag with strictly higher priority than the current tone is granted on the next edge.
  - The counter reloads with the new LEN-1, `tone_o` switches, `play_o` stays 1 and no gap is inserted.
  - The preempted tone is dropped, not re-queued.
- Not defined: no preemption. Higher-priority requests wait in pending until IDLE.

## Structure
- `sound_pkg` holds:
  - `tone_t` enum (TONE_NONE = 2'd0, TONE_DIR, TONE_GOOD, TONE_BAD);
  - `seq_state_t` enum (IDLE, PLAY, GAP).
- `sound_generator` imports the same `tone_t`.
- One sub-module, `event_edge_det`:
  - parameterised width;
  - sync-reset loads current input;
  - outputs the rising-edge pulse and a change flag.
- Instanced for button/good/bad (width 1) and direction (width 4).

## Test plan
The bench uses BAD_LEN=6, GOOD_LEN=4, DIR_LEN=2, GAP_LEN=2.
- **Reset:** assert `rst` 2 cycles with `goodColl_i` held 1, then release. All outputs are 0 and no tone follows while `goodColl_i` stays 1.
- **Single good event:** `goodColl_i` 0→1 at edge N. `play_o = 1` and `tone_o = 2` after N+1 for 4 cycles, then 0 for 2 cycles, then `busy_o = 0`.
- **Simultaneous events:** good, bad and direction 0→4'b0001 in the same cycle. Tone sequence is 3 (6 cycles), 2 (4 cycles), 1 (2 cycles), with a 3-cycle silence between tones.
- **Mute:**
  - Button pulse mid-PLAY sets `mute_o = 1`, and `play_o = 0` one cycle later.
  - A bad event while muted produces no tone.
  - A second button pulse gives `mute_o = 0`.
- **Preempt:** dir event, then bad event 1 cycle into PLAY.
  - With `SOUND_PREEMPT_EN`: `tone_o` goes 1→3 with no gap and plays 6 cycles.
  - Without it: `tone_o = 1` completes its 2 cycles, then gap, then 3.
- **Direction:**
  - Direction 0001→0001: no event.
  - 0001→0000: no event.
  - 0000→0010: one dir tone.
